// File: rtl/add_serial_pkg.sv
// Shared types and constants for the bit-serial adder arbiter.
// Holds the FSM state type, default sizes and the ID-width helper.
package add_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;

    // Bits needed to index n items; never less than 1.
    function automatic int id_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/add_serial_core.sv
// Bit-serial adder datapath: operand shift registers, carry flop and
// a sum register that fills from the MSB side, LSB first.
module add_serial_core
    import add_serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q;
    logic             sbit, cnext;

    always_comb begin
        sbit  = a_q[0] ^ b_q[0] ^ carry_q;
        cnext = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else if (load) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= 1'b0;
        end else if (shift) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            carry_q <= cnext;
            sum_q   <= {sbit, sum_q[WIDTH-1:1]};
        end
    end

    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: rtl/add_serial_arb.sv
// Round-robin arbiter and sequencer sharing one bit-serial adder among
// NREQ requesters; results leave on a valid/ready port.
module add_serial_arb
    import add_serial_pkg::*;
#(
    parameter  int NREQ  = DEF_NREQ,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int IDW   = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [IDW-1:0]        res_id,
    output logic [WIDTH-1:0]      res_sum,
    output logic                  res_carry
);

    localparam int CW = id_width(WIDTH);

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]  win;
    logic [IDW:0]    idx;
    logic            found;

    // Scan from ptr upward with wrap; first active request wins.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
            if (!found && req[idx[IDW-1:0]]) begin
                found = 1'b1;
                win   = idx[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    id_d    = win;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                ptr_d   = (id_q == IDW'(NREQ-1)) ? '0 : id_q + IDW'(1);
                state_d = ADD;
            end
            ADD: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) state_d = DONE;
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt       = '0;
        if (state_q == LOAD) gnt[id_q] = 1'b1;
        busy      = (state_q != IDLE);
        res_valid = (state_q == DONE);
        res_id    = id_q;
    end

    add_serial_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst   (rst),
        .load  (state_q == LOAD),
        .shift (state_q == ADD),
        .a     (a_in[id_q*WIDTH +: WIDTH]),
        .b     (b_in[id_q*WIDTH +: WIDTH]),
        .sum   (res_sum),
        .carry (res_carry)
    );

endmodule

// File: tb/tb_add_serial_arb.sv
// Directed and randomized checks of add_serial_arb against an arithmetic
// reference model (plain A+B and round-robin over the request mask).
module tb_add_serial_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in, b_in;
    logic [NREQ-1:0]       gnt;
    logic                  busy, res_valid, res_ready, res_carry;
    logic [1:0]            res_id;
    logic [WIDTH-1:0]      res_sum;

    int n_cmp, n_err, cyc, ptr_m, last_valid_cyc;

    add_serial_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_sum   (res_sum),
        .res_carry (res_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction from IDLE back to IDLE, checked against the model.
    task automatic run_op(input logic [NREQ-1:0] reqv, input bit hold, input int dly,
                          input bit mutate, input bit chk_gap);
        int       exp_id;
        logic [7:0] ea, eb;
        logic [8:0] s;
        res_ready = (dly == 0);
        req = reqv;
        exp_id = 0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (reqv[(ptr_m + k) % NREQ]) exp_id = (ptr_m + k) % NREQ;
        tick();
        check("gnt_load", 32'(gnt), 32'(1 << exp_id));
        check("busy_load", 32'(busy), 32'd1);
        ea = a_in[exp_id*WIDTH +: WIDTH];
        eb = b_in[exp_id*WIDTH +: WIDTH];
        ptr_m = (exp_id + 1) % NREQ;
        if (!hold) req[exp_id] = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            tick();
            if (mutate && k == 2) a_in[exp_id*WIDTH +: WIDTH] = 8'hFF;
        end
        check("valid_add", 32'(res_valid), 32'd0);
        check("gnt_add", 32'(gnt), 32'd0);
        tick();
        s = 9'(ea) + 9'(eb);
        check("valid_done", 32'(res_valid), 32'd1);
        check("sum", 32'(res_sum), 32'(s[7:0]));
        check("carry", 32'(res_carry), 32'(s[8]));
        check("id", 32'(res_id), 32'(exp_id));
        if (chk_gap) check("issue_gap", 32'(cyc - last_valid_cyc), 32'd11);
        last_valid_cyc = cyc;
        for (int k = 0; k < dly; k++) begin
            tick();
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_sum", 32'(res_sum), 32'(s[7:0]));
            check("hold_carry", 32'(res_carry), 32'(s[8]));
            check("hold_id", 32'(res_id), 32'(exp_id));
        end
        res_ready = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(res_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        ptr_m = 0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; ptr_m = 0; last_valid_cyc = 0;
        rst = 1'b1; req = '0; a_in = '0; b_in = '0; res_ready = 1'b1;
        do_reset();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_id", 32'(res_id), 32'd0);
        check("rst_sum", 32'(res_sum), 32'd0);
        check("rst_carry", 32'(res_carry), 32'd0);

        // Single request on requester 0
        a_in[0 +: 8] = 8'h5A; b_in[0 +: 8] = 8'h3C;
        run_op(4'b0001, 1'b0, 0, 1'b0, 1'b0);

        // Overflow on requester 2
        a_in[16 +: 8] = 8'hFF; b_in[16 +: 8] = 8'h01;
        run_op(4'b0100, 1'b0, 0, 1'b0, 1'b0);

        // Backpressure: five DONE cycles with res_ready low
        a_in[24 +: 8] = 8'hC3; b_in[24 +: 8] = 8'h77;
        run_op(4'b1000, 1'b0, 5, 1'b0, 1'b0);

        // Operand change after grant must not affect the result
        a_in[8 +: 8] = 8'h10; b_in[8 +: 8] = 8'h22;
        run_op(4'b0010, 1'b0, 0, 1'b1, 1'b0);

        // All four requests held: order 0,1,2,3,0, one result every 11 cycles
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            a_in[i*8 +: 8] = 8'(8'h11 * (i + 1));
            b_in[i*8 +: 8] = 8'(8'hF0 - 8'h21 * i);
        end
        for (int n = 0; n < 5; n++) run_op(4'b1111, 1'b1, 0, 1'b0, n > 0);
        req = '0;

        // Reset during ADD cycle 4 discards the operation
        a_in[16 +: 8] = 8'h44; b_in[16 +: 8] = 8'h55;
        req = 4'b0100;
        tick();
        check("rst_mid_gnt", 32'(gnt), 32'b0100);
        req = '0;
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ptr_m = 0;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_gnt", 32'(gnt), 32'd0);
        check("rstmid_valid", 32'(res_valid), 32'd0);
        check("rstmid_sum", 32'(res_sum), 32'd0);
        check("rstmid_carry", 32'(res_carry), 32'd0);
        check("rstmid_id", 32'(res_id), 32'd0);
        for (int k = 0; k < WIDTH + 3; k++) begin
            tick();
            check("rstmid_novalid", 32'(res_valid), 32'd0);
        end
        run_op(4'b1111, 1'b0, 0, 1'b0, 1'b0);

        // Randomized masks, operands and backpressure
        for (int n = 0; n < 16; n++) begin
            a_in = {$urandom, $urandom};
            b_in = {$urandom, $urandom};
            run_op(4'($urandom_range(1, 15)), 1'b0, int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/add_serial_arb.md
# add_serial_arb

Round-robin arbiter and sequencer that shares one bit-serial adder datapath between `NREQ` requesters. It grants one requester at a time and captures that requester's operands. It then clocks the serial adder for exactly `WIDTH` cycles, LSB first, and presents the sum, carry-out and requester ID on a valid/ready result port. It sits between the requesting control blocks and the serial add datapath.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `WIDTH`, 8, operand and sum width in bits (2..32)
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  NREQ  request per requester; held high until the matching `gnt` bit
- `a_in`  in  NREQ*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH]
- `b_in`  in  NREQ*WIDTH  operand B, same slicing as `a_in`
- `gnt`  out  NREQ  one-hot grant, high for one cycle in LOAD
- `busy`  out  1  high in every state except IDLE
- `res_valid`  out  1  result valid; high in DONE only
- `res_ready`  in  1  result consumer ready
- `res_id`  out  clog2(NREQ)  index of the granted requester
- `res_sum`  out  WIDTH  (A+B) mod 2^WIDTH
- `res_carry`  out  1  carry-out of bit WIDTH-1

## Operation
- FSM states: IDLE, LOAD, ADD, DONE.
- IDLE: if any `req` bit is high, select the winner by round-robin starting at `ptr`, register its index into `res_id`, and go to LOAD. With no request, stay in IDLE.
- LOAD (1 cycle):
  - `gnt[res_id]`=1.
  - Capture that requester's A and B slices into the shift registers.
  - Clear `carry` and the bit counter.
  - Set `ptr` = `res_id`+1, wrapping NREQ-1 to 0.
  - Go to ADD.
- ADD (WIDTH cycles):
  - Each cycle: sum bit = a[0]^b[0]^carry; carry = majority(a[0],b[0],carry).
  - Sum bit shifts into `res_sum` from the MSB side. A and B shift right by 1. Counter increments.
  - When counter = WIDTH-1, go to DONE.
- DONE:
  - `res_valid`=1.
  - `res_sum`, `res_carry` and `res_id` stay stable until the cycle `res_valid`&&`res_ready`; that transfer cycle takes the FSM to IDLE.
- Round-robin: after serving i, requester i has lowest priority. A requester cannot be granted twice while another requester holds `req` high.
- `req`/operand changes after the `gnt` cycle do not affect the operation in flight. A `req` still high in IDLE after its grant counts as a new request.
- A `req` dropped before grant is ignored; no grant is issued to it.
- Reset values:
  - State IDLE, `ptr`=0, counter=0.
  - `gnt`=0, `busy`=0, `res_valid`=0.
  - `res_id`=0, `res_sum`=0, `res_carry`=0.
- Reset in any state, including mid-ADD or DONE, discards the operation; no result is produced.

## Timing
- `req` high at edge t (FSM in IDLE): LOAD and `gnt` during cycle t+1.
- ADD occupies cycles t+2 .. t+WIDTH+1.
- `res_valid` is first high in cycle t+WIDTH+2.
- Minimum issue interval with `res_ready` tied high: WIDTH+3 cycles (IDLE, LOAD, WIDTH×ADD, DONE).
- All outputs are registered or decoded from state only; there is no combinational path from `req` or `res_ready` to any output.
- `res_ready` low in DONE: hold DONE indefinitely. New requests queue on `req` meanwhile.

## Structure
- Shared package `add_serial_pkg` holds:
  - the state enum (IDLE, LOAD, ADD, DONE) as a 2-bit type;
  - default `NREQ`/`WIDTH` constants;
  - an ID-width function clog2(NREQ), minimum 1.
- One sub-module, `add_serial_core`:
  - inputs: load, shift, a, b (WIDTH);
  - outputs: sum (WIDTH), carry;
  - contents: the A/B shift registers, carry flop and sum shift register.
- `add_serial_arb` holds the FSM, counter, round-robin pointer and winner selection.

## Test plan
- Single request, `req`=0001, A=8'h5A, B=8'h3C, `res_ready`=1 -> `gnt`=0001 at t+1, `res_valid` at t+10, `res_sum`=8'h96, `res_carry`=0, `res_id`=0.
- Overflow, requester 2, A=8'hFF, B=8'h01 -> `res_sum`=8'h00, `res_carry`=1, `res_id`=2.
- All four `req` held high, operands distinct, `res_ready`=1 -> grant order 0,1,2,3,0. Each result is correct and `res_valid` asserts every 11 cycles.
- Backpressure: `res_ready`=0 for 5 cycles in DONE -> `res_valid` and result stay stable. Transfer happens on the first `res_ready`=1 cycle, with IDLE next cycle.
- Operands change after `gnt` (A 8'h10→8'hFF mid-ADD) -> result uses the captured 8'h10.
- `rst` pulsed at ADD cycle 4 -> next cycle all outputs are 0 and the state is IDLE. No `res_valid` appears, and the following request is granted to requester 0.
